ifetch_mem_responder: RTL and testbench



---
 rtl/ifetch_mem_responder.sv | 152 +++++++++++++++
 tb/tb_ifetch_mem_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_mem_responder.sv
// Fetch-side memory responder: turns a fetch address into a two-beat line read and returns the 128-bit line.
// Optional one-entry line buffer enabled by defining IFETCH_RESP_LINEBUF_EN.
module ifetch_mem_responder #(
    parameter int ADDR_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pc_index_valid,
    input  logic [ADDR_W-1:0] pc_index,
    output logic              pc_index_ready,
    output logic              pc_operation_done,
    output logic [127:0]      pc_read_inst,
    input  logic              redirect_valid,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_resp_data,
    input  logic              linebuf_inval,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for a fetch request
    // REQ   | burst request presented to memory
    // WAIT  | collecting the two response beats
    // DONE  | line assembled; deliver unless killed
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state, state_next;
    logic              kill;
    logic              beat;
    logic [ADDR_W-5:0] line_tag;
    logic [127:0]      asm_line;
    logic              accept;
    logic              deliver;
    logic              lb_hit;
    logic [3:0]        unused_offset;

    assign unused_offset = pc_index[3:0];

`ifdef IFETCH_RESP_LINEBUF_EN
    logic              lb_valid;
    logic [ADDR_W-5:0] lb_tag;
    logic [127:0]      lb_data;

    assign lb_hit = lb_valid && (lb_tag == pc_index[ADDR_W-1:4]);

    // An invalidate in the same cycle as a delivery leaves the entry invalid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lb_valid <= 1'b0;
            lb_tag   <= '0;
            lb_data  <= '0;
        end else begin
            if (linebuf_inval)
                lb_valid <= 1'b0;
            else if (deliver)
                lb_valid <= 1'b1;
            if (deliver) begin
                lb_tag  <= line_tag;
                lb_data <= asm_line;
            end
        end
    end
`else
    logic unused_inval;

    assign lb_hit       = 1'b0;
    assign unused_inval = linebuf_inval;
`endif

    always_comb begin
        state_next        = state;
        pc_index_ready    = 1'b0;
        pc_operation_done = 1'b0;
        accept            = 1'b0;
        deliver           = 1'b0;
        case (state)
            IDLE: begin
                pc_index_ready = !redirect_valid;
                if (pc_index_valid && !redirect_valid) begin
                    accept     = 1'b1;
                    state_next = lb_hit ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_req_ready)
                    state_next = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid && beat)
                    state_next = DONE;
            end
            DONE: begin
                pc_operation_done = !kill && !redirect_valid;
                deliver           = !kill && !redirect_valid;
                state_next        = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A redirect only suppresses delivery; the burst itself always runs to completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            kill         <= 1'b0;
            beat         <= 1'b0;
            line_tag     <= '0;
            asm_line     <= '0;
            pc_read_inst <= '0;
        end else begin
            if (accept) begin
                kill     <= 1'b0;
                line_tag <= pc_index[ADDR_W-1:4];
`ifdef IFETCH_RESP_LINEBUF_EN
                if (lb_hit)
                    asm_line <= lb_data;
`endif
            end else if (redirect_valid && state != IDLE) begin
                kill <= 1'b1;
            end

            if (state == REQ && mem_req_ready)
                beat <= 1'b0;
            else if (state == WAIT && mem_resp_valid)
                beat <= beat + 1'b1;

            if (state == WAIT && mem_resp_valid) begin
                if (beat)
                    asm_line[127:64] <= mem_resp_data;
                else
                    asm_line[63:0]   <= mem_resp_data;
            end

            if (deliver)
                pc_read_inst <= asm_line;
        end
    end

    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = {line_tag, 4'b0000};
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Directed bench for ifetch_mem_responder: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_ifetch_mem_responder;

    logic         clock = 1'b0;
    logic         reset;
    logic         pc_index_valid;
    logic [63:0]  pc_index;
    logic         pc_index_ready;
    logic         pc_operation_done;
    logic [127:0] pc_read_inst;
    logic         redirect_valid;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [63:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [63:0]  mem_resp_data;
    logic         linebuf_inval;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    ifetch_mem_responder #(.ADDR_W(64)) dut (
        .clock             (clock),
        .reset             (reset),
        .pc_index_valid    (pc_index_valid),
        .pc_index          (pc_index),
        .pc_index_ready    (pc_index_ready),
        .pc_operation_done (pc_operation_done),
        .pc_read_inst      (pc_read_inst),
        .redirect_valid    (redirect_valid),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data),
        .linebuf_inval     (linebuf_inval),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         valid;
        logic [63:0]  pc;
        logic         redir;
        logic         rreq;
        logic         rresp;
        logic [63:0]  data;
        logic         e_ready;
        logic         e_done;
        logic         e_reqv;
        logic         e_busy;
        logic [63:0]  e_addr;
        logic [127:0] e_inst;
    } vec_t;

    localparam logic [127:0] LINE1 = 128'h5555_6666_7777_8888_1111_2222_3333_4444;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Zero-delay miss: handshake at T, request at T+1, beats T+2/T+3, done at T+4.
    task automatic do_miss(input logic [63:0] addr, input logic [63:0] d0, input logic [63:0] d1);
        pc_index_valid = 1'b1;
        pc_index       = addr;
        mem_req_ready  = 1'b1;
        #1 check("miss_ready_T", pc_index_ready, 1);
        tick();
        pc_index_valid = 1'b0;
        #1 check("miss_reqv_T1", mem_req_valid, 1);
        check("miss_addr_T1", mem_req_addr, {addr[63:4], 4'h0});
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = d0;
        #1 check("miss_done_T2", pc_operation_done, 0);
        tick();
        mem_resp_data = d1;
        tick();
        mem_resp_valid = 1'b0;
        #1 check("miss_done_T4", pc_operation_done, 1);
        tick();
        mem_req_ready = 1'b0;
        #1 check("miss_inst_T5", pc_read_inst, {d1, d0});
        check("miss_ready_T5", pc_index_ready, 1);
    endtask

    initial begin
        vec_t vecs[8];

        vecs[0] = '{1'b1, 64'h8000_0004, 1'b0, 1'b0, 1'b0, 64'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 128'h0};
        vecs[1] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0,
                    1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0000, 128'h0};
        vecs[2] = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 64'h1111_2222_3333_4444,
                    1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0000, 128'h0};
        vecs[3] = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 64'h5555_6666_7777_8888,
                    1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0000, 128'h0};
        vecs[4] = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0,
                    1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0000, 128'h0};
        vecs[5] = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0000, LINE1};
        vecs[6] = '{1'b1, 64'h200, 1'b1, 1'b0, 1'b0, 64'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 64'h8000_0000, LINE1};
        vecs[7] = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0000, LINE1};

        reset          = 1'b1;
        pc_index_valid = 1'b0;
        pc_index       = '0;
        redirect_valid = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        linebuf_inval  = 1'b0;
        tick();
        tick();
        check("rst_ready", pc_index_ready, 1);
        check("rst_done", pc_operation_done, 0);
        check("rst_reqv", mem_req_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", mem_req_addr, 0);
        check("rst_inst", pc_read_inst, 0);
        redirect_valid = 1'b1;
        #1 check("rst_ready_redir", pc_index_ready, 0);
        redirect_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Single miss followed by redirect-blocked handshake in IDLE.
        for (int i = 0; i < 8; i++) begin
            pc_index_valid = vecs[i].valid;
            pc_index       = vecs[i].pc;
            redirect_valid = vecs[i].redir;
            mem_req_ready  = vecs[i].rreq;
            mem_resp_valid = vecs[i].rresp;
            mem_resp_data  = vecs[i].data;
            #1;
            check($sformatf("vec%0d_ready", i), pc_index_ready, vecs[i].e_ready);
            check($sformatf("vec%0d_done", i), pc_operation_done, vecs[i].e_done);
            check($sformatf("vec%0d_reqv", i), mem_req_valid, vecs[i].e_reqv);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d_addr", i), mem_req_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_inst", i), pc_read_inst, vecs[i].e_inst);
            tick();
        end
        pc_index_valid = 1'b0;
        redirect_valid = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;

        // Backpressure on request and gaps between beats.
        pc_index_valid = 1'b1;
        pc_index       = 64'h1238;
        tick();
        pc_index_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("bp_reqv%0d", i), mem_req_valid, 1);
            check($sformatf("bp_addr%0d", i), mem_req_addr, 64'h1230);
            check($sformatf("bp_ready%0d", i), pc_index_ready, 0);
            tick();
        end
        mem_req_ready = 1'b1;
        #1 check("bp_reqv3", mem_req_valid, 1);
        check("bp_addr3", mem_req_addr, 64'h1230);
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hAAAA_0000_0000_000A;
        tick();
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 check($sformatf("bp_gap_done%0d", i), pc_operation_done, 0);
            check($sformatf("bp_gap_ready%0d", i), pc_index_ready, 0);
            tick();
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hBBBB_0000_0000_000B;
        #1 check("bp_beat1_done", pc_operation_done, 0);
        tick();
        mem_resp_valid = 1'b0;
        #1 check("bp_done", pc_operation_done, 1);
        check("bp_ready_in_done", pc_index_ready, 0);
        tick();
        check("bp_done_after", pc_operation_done, 0);
        check("bp_ready_after", pc_index_ready, 1);
        check("bp_inst", pc_read_inst, 128'hBBBB_0000_0000_000B_AAAA_0000_0000_000A);

        // Redirect pulse after beat 0.
        pc_index_valid = 1'b1;
        pc_index       = 64'h3000;
        mem_req_ready  = 1'b1;
        tick();
        pc_index_valid = 1'b0;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hCCCC;
        tick();
        mem_resp_valid = 1'b0;
        redirect_valid = 1'b1;
        #1 check("rw_ready_redir", pc_index_ready, 0);
        tick();
        redirect_valid = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDDDD;
        #1 check("rw_busy_beat1", busy, 1);
        tick();
        mem_resp_valid = 1'b0;
        #1 check("rw_done_killed", pc_operation_done, 0);
        check("rw_busy_done", busy, 1);
        tick();
        check("rw_ready_after", pc_index_ready, 1);
        check("rw_busy_after", busy, 0);
        check("rw_inst_kept", pc_read_inst, 128'hBBBB_0000_0000_000B_AAAA_0000_0000_000A);

        // Redirect in the DONE cycle.
        pc_index_valid = 1'b1;
        pc_index       = 64'h4000;
        mem_req_ready  = 1'b1;
        tick();
        pc_index_valid = 1'b0;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hEEEE;
        tick();
        mem_resp_data  = 64'hFFFF;
        tick();
        mem_resp_valid = 1'b0;
        redirect_valid = 1'b1;
        #1 check("rd_done_killed", pc_operation_done, 0);
        check("rd_busy", busy, 1);
        tick();
        redirect_valid = 1'b0;
        #1 check("rd_ready_after", pc_index_ready, 1);
        check("rd_inst_kept", pc_read_inst, 128'hBBBB_0000_0000_000B_AAAA_0000_0000_000A);

        // Async reset in WAIT, then a stray beat in IDLE.
        pc_index_valid = 1'b1;
        pc_index       = 64'h5000;
        mem_req_ready  = 1'b1;
        tick();
        pc_index_valid = 1'b0;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h1234;
        tick();
        mem_resp_valid = 1'b0;
        reset          = 1'b1;
        #1 check("ar_busy", busy, 0);
        check("ar_reqv", mem_req_valid, 0);
        check("ar_addr", mem_req_addr, 0);
        check("ar_inst", pc_read_inst, 0);
        check("ar_ready", pc_index_ready, 1);
        check("ar_done", pc_operation_done, 0);
        tick();
        reset = 1'b0;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDEAD_BEEF;
        #1 check("ar_stray_busy", busy, 0);
        tick();
        mem_resp_valid = 1'b0;
        #1 check("ar_stray_ready", pc_index_ready, 1);
        check("ar_stray_inst", pc_read_inst, 0);
        do_miss(64'h6000, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);

`ifdef IFETCH_RESP_LINEBUF_EN
        do_miss(64'h100, 64'h0000_0000_0000_0A0A, 64'h0000_0000_0000_0B0B);
        pc_index_valid = 1'b1;
        pc_index       = 64'h108;
        #1 check("lb_ready", pc_index_ready, 1);
        tick();
        pc_index_valid = 1'b0;
        #1 check("lb_hit_done", pc_operation_done, 1);
        check("lb_hit_reqv", mem_req_valid, 0);
        tick();
        check("lb_hit_inst", pc_read_inst, 128'h0000_0000_0000_0B0B_0000_0000_0000_0A0A);
        check("lb_hit_reqv2", mem_req_valid, 0);
        linebuf_inval = 1'b1;
        tick();
        linebuf_inval = 1'b0;
        do_miss(64'h100, 64'h0000_0000_0000_0C0C, 64'h0000_0000_0000_0D0D);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
